// File: rtl/r4_pkg.sv
// r4_pkg: constants and types shared by the radix-4 frame loader and the
// butterfly that consumes its frames.
//   DW_DEFAULT : default sample component width
//   NPTS       : samples per radix-4 frame
//   cplx_t     : one complex sample {re, im}
//   ctl_t      : twiddle controls {c3, c2, c1}
//   slot_idx() : arrival-count to storage-slot mapping
// Build macro BITREV_ORDER_EN selects bit-reversed slot order; when it is
// undefined, samples land in natural order.
package r4_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int NPTS       = 4;

    typedef logic [2:0] ctl_t;

    typedef struct packed {
        logic [DW_DEFAULT-1:0] re;
        logic [DW_DEFAULT-1:0] im;
    } cplx_t;

    // Storage slot for the n-th sample of a frame.
    function automatic logic [1:0] slot_idx(input logic [1:0] n);
`ifdef BITREV_ORDER_EN
        return {n[0], n[1]};
`else
        return n;
`endif
    endfunction

endpackage

// File: rtl/r4_frame_bank.sv
// r4_frame_bank: one frame buffer of the loader's ping-pong pair.
// Four {re, im} slots with one indexed write port, a ctl register with its
// own write enable, and all slots visible in parallel.
//   CLK, RST        : clock, synchronous active-high reset (clears contents)
//   we, waddr       : slot write enable and slot index
//   wre, wim        : sample being written
//   ctl_we, wctl    : twiddle-control write enable and value
//   re0..3, im0..3  : slot contents
//   ctl             : stored twiddle controls
module r4_frame_bank
    import r4_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [1:0]    waddr,
    input  logic [DW-1:0] wre,
    input  logic [DW-1:0] wim,
    input  logic          ctl_we,
    input  ctl_t          wctl,
    output logic [DW-1:0] re0,
    output logic [DW-1:0] re1,
    output logic [DW-1:0] re2,
    output logic [DW-1:0] re3,
    output logic [DW-1:0] im0,
    output logic [DW-1:0] im1,
    output logic [DW-1:0] im2,
    output logic [DW-1:0] im3,
    output ctl_t          ctl
);

    logic [DW-1:0] re_r [NPTS];
    logic [DW-1:0] im_r [NPTS];
    ctl_t          ctl_r;

    // Slot and ctl storage with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NPTS; i++) begin
                re_r[i] <= '0;
                im_r[i] <= '0;
            end
            ctl_r <= 3'b000;
        end else begin
            if (we) begin
                re_r[waddr] <= wre;
                im_r[waddr] <= wim;
            end
            if (ctl_we) begin
                ctl_r <= wctl;
            end
        end
    end

    assign re0 = re_r[0];
    assign re1 = re_r[1];
    assign re2 = re_r[2];
    assign re3 = re_r[3];
    assign im0 = im_r[0];
    assign im1 = im_r[1];
    assign im2 = im_r[2];
    assign im3 = im_r[3];
    assign ctl = ctl_r;

endmodule

// File: rtl/r4_frame_loader.sv
// r4_frame_loader: groups a serial stream of complex samples into 4-sample
// frames for the radix-4 butterfly, double-buffered so one frame loads while
// the previous one waits to be consumed.
//   CLK, RST                 : clock, synchronous active-high reset
//   s_valid/s_ready          : sample handshake; s_re, s_im, s_ctl payload
//   flush                    : drop the partially loaded frame
//   m_valid/m_ready          : frame handshake
//   xr0..3, xi0..3, c1..c3   : presented frame, driven only from registers
//   occ                      : number of full banks (0..2)
// Build macro BITREV_ORDER_EN: when defined, arrival order 0,1,2,3 fills
// slots 0,2,1,3; otherwise slots fill in natural order.
module r4_frame_loader
    import r4_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    input  logic [2:0]    s_ctl,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] xr0,
    output logic [DW-1:0] xr1,
    output logic [DW-1:0] xr2,
    output logic [DW-1:0] xr3,
    output logic [DW-1:0] xi0,
    output logic [DW-1:0] xi1,
    output logic [DW-1:0] xi2,
    output logic [DW-1:0] xi3,
    output logic          c1,
    output logic          c2,
    output logic          c3,
    output logic [1:0]    occ
);

    logic [1:0]    full_r;
    logic [1:0]    full_nxt_s;
    logic          wbank_r;
    logic          rbank_r;
    logic [1:0]    wcnt_r;

    logic          s_ready_s;
    logic          accept_s;
    logic          complete_s;
    logic          consume_s;

    logic [DW-1:0] bre_s [2][NPTS];
    logic [DW-1:0] bim_s [2][NPTS];
    ctl_t          bctl_s [2];

    // The write bank is free exactly when its full flag is clear; flush
    // wins over a simultaneous accept.
    assign s_ready_s  = !RST && !full_r[wbank_r];
    assign accept_s   = s_valid && s_ready_s && !flush;
    assign complete_s = accept_s && (wcnt_r == 2'd3);
    assign consume_s  = !RST && full_r[rbank_r] && m_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        r4_frame_bank #(.DW(DW)) u_bank (
            .CLK    (CLK),
            .RST    (RST),
            .we     (accept_s && (wbank_r == 1'(b))),
            .waddr  (slot_idx(wcnt_r)),
            .wre    (s_re),
            .wim    (s_im),
            .ctl_we (accept_s && (wcnt_r == 2'd0) && (wbank_r == 1'(b))),
            .wctl   (s_ctl),
            .re0    (bre_s[b][0]),
            .re1    (bre_s[b][1]),
            .re2    (bre_s[b][2]),
            .re3    (bre_s[b][3]),
            .im0    (bim_s[b][0]),
            .im1    (bim_s[b][1]),
            .im2    (bim_s[b][2]),
            .im3    (bim_s[b][3]),
            .ctl    (bctl_s[b])
        );
    end

    // Full-flag update. A completing frame and a consume always target
    // different banks (write bank is empty, read bank is full), so both
    // can apply at the same edge.
    always_comb begin
        full_nxt_s = full_r;
        if (complete_s) begin
            full_nxt_s[wbank_r] = 1'b1;
        end else begin
            full_nxt_s[wbank_r] = full_r[wbank_r];
        end
        if (consume_s) begin
            full_nxt_s[rbank_r] = 1'b0;
        end else begin
            full_nxt_s[rbank_r] = full_nxt_s[rbank_r];
        end
    end

    // Pointer, sample counter and full-flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_r  <= 2'b00;
            wbank_r <= 1'b0;
            rbank_r <= 1'b0;
            wcnt_r  <= 2'd0;
        end else begin
            full_r <= full_nxt_s;
            if (flush) begin
                wcnt_r <= 2'd0;
            end else if (accept_s) begin
                wcnt_r <= wcnt_r + 2'd1;
            end else begin
                wcnt_r <= wcnt_r;
            end
            if (complete_s) begin
                wbank_r <= ~wbank_r;
            end else begin
                wbank_r <= wbank_r;
            end
            if (consume_s) begin
                rbank_r <= ~rbank_r;
            end else begin
                rbank_r <= rbank_r;
            end
        end
    end

    // Output selection from the read bank; everything is forced low while
    // reset is held.
    always_comb begin
        if (RST) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            occ     = 2'd0;
            xr0 = '0; xr1 = '0; xr2 = '0; xr3 = '0;
            xi0 = '0; xi1 = '0; xi2 = '0; xi3 = '0;
            c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        end else begin
            s_ready = s_ready_s;
            m_valid = full_r[rbank_r];
            occ     = {1'b0, full_r[0]} + {1'b0, full_r[1]};
            xr0 = bre_s[rbank_r][0]; xr1 = bre_s[rbank_r][1];
            xr2 = bre_s[rbank_r][2]; xr3 = bre_s[rbank_r][3];
            xi0 = bim_s[rbank_r][0]; xi1 = bim_s[rbank_r][1];
            xi2 = bim_s[rbank_r][2]; xi3 = bim_s[rbank_r][3];
            c1 = bctl_s[rbank_r][0];
            c2 = bctl_s[rbank_r][1];
            c3 = bctl_s[rbank_r][2];
        end
    end

endmodule

// File: tb/tb_r4_frame_loader.sv
// tb_r4_frame_loader: self-checking bench for r4_frame_loader (DW=4).
// Reference model: a FIFO of at most two completed frames plus the frame
// being assembled. Honours BITREV_ORDER_EN the same way as the design build.
module tb_r4_frame_loader;

    localparam int DW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_re;
    logic [DW-1:0] s_im;
    logic [2:0]    s_ctl;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] xr0, xr1, xr2, xr3;
    logic [DW-1:0] xi0, xi1, xi2, xi3;
    logic          c1, c2, c3;
    logic [1:0]    occ;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    r4_frame_loader #(.DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_ctl(s_ctl),
        .flush(flush),
        .m_valid(m_valid), .m_ready(m_ready),
        .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
        .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
        .c1(c1), .c2(c2), .c3(c3),
        .occ(occ)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [2:0]  ctl;
    } frame_t;

    frame_t frames[$];
    frame_t cur;
    int     cnt;

    function automatic int slot_of(input int n);
`ifdef BITREV_ORDER_EN
        return (n % 2) * 2 + n / 2;
`else
        return n;
`endif
    endfunction

    function automatic void model_reset();
        frames.delete();
        cur = '0;
        cnt = 0;
    endfunction

    function automatic void model_step(input logic v, input logic [3:0] re,
                                       input logic [3:0] im, input logic [2:0] ctl,
                                       input logic fl, input logic mr);
        bit rdy, vld, acc;
        int s;
        rdy = frames.size() < 2;
        vld = frames.size() > 0;
        acc = v && rdy && !fl;
        if (vld && mr) void'(frames.pop_front());
        if (fl) begin
            cnt = 0;
        end else if (acc) begin
            s = slot_of(cnt);
            cur.re[s*4 +: 4] = re;
            cur.im[s*4 +: 4] = im;
            if (cnt == 0) cur.ctl = ctl;
            cnt++;
            if (cnt == 4) begin
                frames.push_back(cur);
                cnt = 0;
            end
        end
    endfunction

    // Expected {s_ready, m_valid, occ, xr0..3, xi0..3, c3, c2, c1}; frame
    // fields only matter while a frame is presented.
    function automatic logic [38:0] expected();
        logic [38:0] e;
        frame_t f;
        e = '0;
        e[38]    = frames.size() < 2;
        e[37]    = frames.size() > 0;
        e[36:35] = 2'(frames.size());
        if (frames.size() > 0) begin
            f = frames[0];
            e[34:0] = {f.re[3:0], f.re[7:4], f.re[11:8], f.re[15:12],
                       f.im[3:0], f.im[7:4], f.im[11:8], f.im[15:12], f.ctl};
        end
        return e;
    endfunction

    function automatic logic [38:0] observed();
        logic [38:0] o;
        o = {s_ready, m_valid, occ, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, c3, c2, c1};
        if (frames.size() == 0) o[34:0] = '0;
        return o;
    endfunction

    // Apply one cycle of inputs (called at negedge), advance model at the edge.
    task automatic drive(input logic v, input logic [3:0] re, input logic [3:0] im,
                         input logic [2:0] ctl, input logic fl, input logic mr);
        s_valid = v; s_re = re; s_im = im; s_ctl = ctl; flush = fl; m_ready = mr;
        @(posedge CLK);
        model_step(v, re, im, ctl, fl, mr);
        @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [38:0] got;
        RST = 1'b1; s_valid = 1'b1; s_re = 4'd7; s_im = 4'd5; s_ctl = 3'd7;
        flush = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); @(negedge CLK);
            got = {s_ready, m_valid, occ, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, c3, c2, c1};
            vectors++;
            if (got !== 39'd0) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: got %h want 0", i, got);
            end
        end
        model_reset();
        RST = 1'b0; s_valid = 1'b0;
        @(posedge CLK); @(negedge CLK);
        got = {s_ready, m_valid, occ, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, c3, c2, c1};
        vectors++;
        if (got !== {1'b1, 38'd0}) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", got, {1'b1, 38'd0});
        end
    endtask

    task automatic test_single_frame();
        logic [3:0]  re_t [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        logic [3:0]  im_t [4] = '{4'd8, 4'd9, 4'd10, 4'd11};
        logic [15:0] xr_want, xi_want;
        logic [38:0] got, want;
`ifdef BITREV_ORDER_EN
        xr_want = {4'd1, 4'd3, 4'd2, 4'd4};
        xi_want = {4'd8, 4'd10, 4'd9, 4'd11};
`else
        xr_want = {4'd1, 4'd2, 4'd3, 4'd4};
        xi_want = {4'd8, 4'd9, 4'd10, 4'd11};
`endif
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, re_t[i], im_t[i], (i == 0) ? 3'b101 : 3'b010, 1'b0, 1'b1);
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL single cyc %0d: got %h want %h", i, got, want);
            end
        end
        vectors++;
        if ({m_valid, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, c1, c2, c3} !==
            {1'b1, xr_want, xi_want, 3'b101}) begin
            miscompares++;
            $display("FAIL single_frame: got %h want %h",
                     {m_valid, xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3, c1, c2, c3},
                     {1'b1, xr_want, xi_want, 3'b101});
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
        vectors++;
        if ({m_valid, occ} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_consumed: got %b want 000", {m_valid, occ});
        end
    endtask

    task automatic test_backpressure();
        int k = 0, hold = 0, cyc = 0;
        bit rel = 0;
        logic mr;
        bit acc_exp;
        logic [38:0] got, want;
        while (k < 12 && cyc < 40) begin
            mr = 1'b0;
            if (k == 8 && frames.size() == 2 && !rel) begin
                vectors++;
                if ({s_ready, occ} !== 3'b010) begin
                    miscompares++;
                    $display("FAIL bp_full: got %b want 010", {s_ready, occ});
                end
                hold++;
                if (hold == 3) begin mr = 1'b1; rel = 1; end
            end
            acc_exp = frames.size() < 2;
            drive(1'b1, 4'(k + 1), 4'(15 - k), 3'(k), 1'b0, mr);
            if (acc_exp) k++;
            cyc++;
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL backpressure cyc %0d: got %h want %h", cyc, got, want);
            end
        end
        vectors++;
        if (k != 12 || !rel) begin
            miscompares++;
            $display("FAIL bp_timeout: got %0d accepted want 12", k);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL bp_drain %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_flush();
        logic [38:0] got, want;
        drive(1'b1, 4'd9, 4'd9, 3'b111, 1'b0, 1'b1);
        drive(1'b1, 4'd8, 4'd8, 3'b111, 1'b0, 1'b1);
        drive(1'b1, 4'd7, 4'd7, 3'b111, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(i + 3), 4'(12 - i), (i == 0) ? 3'b011 : 3'b100, 1'b0, 1'b1);
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL flush cyc %0d: got %h want %h", i, got, want);
            end
        end
        vectors++;
        if ({m_valid, c3, c2, c1} !== 4'b1011) begin
            miscompares++;
            $display("FAIL flush_ctl: got %b want 1011", {m_valid, c3, c2, c1});
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        logic [38:0] got, want;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i * 3), 4'(i + 5), 3'(i + 2), 1'b0, (i == 7) ? 1'b1 : 1'b0);
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL simul cyc %0d: got %h want %h", i, got, want);
            end
        end
        vectors++;
        if ({m_valid, occ, xr0} !== {1'b1, 2'd1, 4'd12}) begin
            miscompares++;
            $display("FAIL simul_switch: got %h want %h", {m_valid, occ, xr0}, {1'b1, 2'd1, 4'd12});
        end
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        logic [38:0] got, want;
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 6), 4'(i), 3'b110, 1'b0, 1'b0);
        vectors++;
        if (m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_loaded: got %b want 1", m_valid);
        end
        RST = 1'b1; s_valid = 1'b1;
        @(posedge CLK); @(negedge CLK);
        model_reset();
        vectors++;
        if ({s_ready, m_valid, occ} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_hold: got %b want 0000", {s_ready, m_valid, occ});
        end
        RST = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
        got = observed(); want = expected(); vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL midrst_after: got %h want %h", got, want);
        end
    endtask

    task automatic test_random();
        logic [38:0] got, want;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 3'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            got = observed(); want = expected(); vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_flush();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/r4_frame_loader.md
Name: r4_frame_loader

Overview:
- Upstream stage of the radix-4 butterfly.
- Accepts one complex sample (real and imaginary, DW bits each) per valid/ready handshake and groups every 4 consecutive samples into a frame.
- Presents each frame in parallel on xr0..xr3 / xi0..xi3 together with the frame's twiddle controls c1..c3.
- Ping-pong double buffering lets one frame be loaded while the previous one is held for the butterfly.

Parameters:
- DW, 4, bit width of each real and imaginary sample component; must match the butterfly input width.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_re  in  DW  sample real part.
- s_im  in  DW  sample imaginary part.
- s_ctl  in  3  twiddle controls {c3,c2,c1}; sampled only with the first sample of a frame.
- flush  in  1  synchronous abort of the partially loaded frame.
- m_valid  out  1  a complete frame is presented.
- m_ready  in  1  butterfly consumes the presented frame.
- xr0, xr1, xr2, xr3  out  DW each  frame real parts, slots 0..3.
- xi0, xi1, xi2, xi3  out  DW each  frame imaginary parts, slots 0..3.
- c1, c2, c3  out  1 each  twiddle controls of the presented frame.
- occ  out  2  number of full banks (0..2).

Behaviour:
- Storage: bank[0..1], each holding 4 slots of {re, im} plus a 3-bit ctl register; flags full[0..1]; pointers wbank, rbank (1 bit each); wcnt (2 bits).
- Reset (RST=1 at an edge): all bank data, ctl registers, full flags, wbank, rbank and wcnt clear to 0. While RST is high: s_ready=0, m_valid=0, all x*/c* outputs=0, occ=0.
- s_ready = !RST && !full[wbank]. Accept = s_valid && s_ready.
- On accept:
  - store {s_re, s_im} into bank[wbank] slot idx(wcnt); default idx(n)=n.
  - if wcnt==0, also latch s_ctl into ctl[wbank].
  - wcnt increments and wraps from 3 to 0.
  - on the accept with wcnt==3: set full[wbank] and toggle wbank.
- m_valid = full[rbank]. Outputs always drive bank[rbank] slots and ctl[rbank] directly from registers, with no combinational path from the s_* inputs.
- Consume = m_valid && m_ready: clear full[rbank] and toggle rbank. Outputs must be held stable while m_valid=1 and m_ready=0.
- Latency: 4th sample accepted at edge N gives m_valid=1 in the cycle after edge N. A minimum of 1 cycle applies from final accept to presentation.
- Throughput: one sample per cycle sustained when m_ready is held at 1.
- Simultaneous accept-completes-frame and consume on different banks: both take effect at the same edge.
- Both banks full: s_ready=0 until a consume; the accepting bank frees at that edge, so s_ready=1 in the next cycle.
- flush=1 at an edge: wcnt goes to 0 and any accept in that cycle is discarded. Full banks, rbank and wbank are unchanged. flush has priority over accept.
- occ = full[0] + full[1].
- Mid-operation reset aborts all frames, including presented but unconsumed ones.

Optional Feature:
- Macro BITREV_ORDER_EN.
- When defined: slot index idx(n) = {n[0], n[1]}, a 2-bit reversal. Arrival order 0,1,2,3 fills slots 0,2,1,3, which feeds the butterfly with bit-reversed input ordering.
- When undefined: idx(n)=n, natural order.
- Handshake, latency and ctl capture are identical in both builds.

Decomposition:
- Shared package r4_pkg:
  - DW default constant.
  - NPTS=4.
  - a complex-sample typedef {re, im}.
  - the 3-bit twiddle-control typedef.
- The butterfly also imports this package.
- One natural sub-module: r4_frame_bank (4 slots + ctl register with indexed write port and parallel read).
  - instantiated twice.
  - the top level holds the pointers, wcnt, the full flags and the handshake logic.

Test Plan:
- Reset: hold RST 2 cycles with s_valid=1 -> s_ready=0, m_valid=0, all outputs 0, occ=0; no sample is stored.
- Single frame, m_ready=1: samples (re,im)=(1,8),(2,9),(3,10),(4,11) on consecutive cycles with s_ctl=3'b101 on the first -> next cycle m_valid=1, xr0..3=1,2,3,4, xi0..3=8,9,10,11, c1=1, c2=0, c3=1, consumed the same cycle.
- Backpressure, m_ready=0: stream 12 samples -> s_ready falls after the 8th accept, occ=2, outputs hold frame 1. Raise m_ready for 1 cycle -> frame 2 is presented, s_ready=1 the next cycle, samples 9..12 then load.
- Flush: accept 2 samples, pulse flush together with a valid sample -> that sample is dropped. The next 4 samples form a clean frame with the ctl of the first post-flush sample.
- Simultaneous events: complete frame B on the same edge frame A is consumed -> m_valid stays 1 continuously, the outputs switch to frame B, occ stays 1.
- BITREV_ORDER_EN build: samples re=1,2,3,4 -> xr0..3=1,3,2,4.
